snake_body: RTL and testbench
=============================

Name: snake_body

Overview:
- Holds the snake's segment coordinates on a cell grid and advances the snake one cell per move tick.
- Applies steering, growth and collision detection on each move.
- Hit-tests the current raster pixel (row, col) against the segments each clk.
- Drives snake_r / snake_head into the pixel-colour stage directly downstream.

Parameters:
MAX_LEN, 16, maximum number of segments (length saturates here)
CELL, 20, cell edge in pixels; grid cell (x,y) covers col x*CELL..x*CELL+CELL-1, row y*CELL..y*CELL+CELL-1
GRID_W, 32, grid width in cells (640/CELL)
GRID_H, 24, grid height in cells (480/CELL)
INIT_LEN, 3, length after reset (2..MAX_LEN)
INIT_X, 16, head x cell after reset
INIT_Y, 12, head y cell after reset

Ports:
clk  input  1  pixel/system clock
rst_n  input  1  synchronous active-low reset
move_tick  input  1  one-clk pulse; advance snake one cell
dir_req  input  2  requested direction: 0 up, 1 down, 2 left, 3 right
grow  input  1  one-clk pulse; food eaten, lengthen by one at next move
row  input  9  current raster row (0..479)
col  input  10  current raster column (0..639)
snake_r  output  1  registered: pixel lies inside any body segment (head included)
snake_head  output  1  registered: pixel lies inside the head segment
head_x  output  5  head cell x
head_y  output  5  head cell y
length  output  5  current segment count
game_over  output  1  sticky: wall or self collision occurred

Behaviour:
- Reset is synchronous, active-low on rst_n, clock clk.
- Reset state:
  - length=INIT_LEN; segment i = (INIT_X-i, INIT_Y), segment 0 is the head.
  - cur_dir=right (3); grow_pend=0; game_over=0; snake_r=0; snake_head=0.
  - Segments i >= length are don't-care and never hit-tested.
- grow pulse sets grow_pend=1. grow_pend clears at the next applied move. Multiple grows before one move count once.
- Direction:
  - On move_tick, cur_dir<=dir_req unless dir_req is the exact reverse of cur_dir (up/down, left/right). Reversal requests are ignored and cur_dir is kept.
  - dir_req is sampled only on move_tick.
- Move, on the move_tick cycle when game_over=0:
  - Next head nh = head ±1 in the effective direction (up decrements y).
  - Wall: if nh is outside 0..GRID_W-1 / 0..GRID_H-1 (computed in 6 bits, so 0-1 is detected as out of range), set game_over=1. No segment changes.
  - Self: if nh equals any segment j, for j in 0..length-2, set game_over=1 with no change. The tail (j=length-1) is also checked when grow_pend=1 and length<MAX_LEN, because the tail does not vacate in that case.
  - Otherwise, in the same edge: seg[i]<=seg[i-1] for i>=1, seg[0]<=nh.
  - If grow_pend=1 and length<MAX_LEN: length<=length+1; the old tail is retained as the new last segment.
  - grow_pend is cleared on the move even when length=MAX_LEN; growth is then dropped.
- game_over=1 freezes all segment/length/dir state until reset. move_tick and grow are ignored. Pixel hit-test continues.
- Pixel hit-test:
  - Each segment is compared by range: col>=x*CELL && col<x*CELL+CELL && row>=y*CELL && row<y*CELL+CELL. x*CELL uses 10-bit arithmetic, y*CELL uses 9-bit.
  - Result registered: row/col at edge n produce snake_r/snake_head valid after edge n+1 (latency 1).
  - snake_head implies snake_r.
  - Out-of-screen row/col (row>=480 or col>=640) gives 0.
- Move and hit-test in the same cycle: the hit-test uses the pre-move segments.
- grow and move_tick in the same cycle: growth applies on that move.

Test Plan:
- Reset, then scan col=300..339, row=240..259 → snake_head=1 for col 320..339; snake_r=1 for col 300..339; 0 outside; each output one clk after its inputs.
- 4 move_ticks with dir_req=3 → head_x=20, head_y=12, length=3; pixel (col=400,row=240) snake_head=1.
- cur_dir=right, dir_req=2 (reverse) on move_tick → treated as right; head_x increments; game_over=0.
- grow pulse then move_tick → length 3→4; tail cell unchanged; 13 further grow+move pairs → length saturates at 16; the next grow+move leaves length=16.
- Head at x=31 moving right → game_over=1, head_x stays 31; later move_tick/grow change nothing; rst_n=0 for one clk restores the reset state.
- Length 5, sequence up, left, down (head re-enters its own body) → game_over=1 on the colliding tick; segments unchanged from the previous tick.

Source files
------------

// File: rtl/snake_if.sv
// Snake body bus: steering/growth/raster inputs and hit-test/status outputs.
// The game controller drives the master side; snake_body is the slave.
interface snake_if;
    logic       move_tick;
    logic [1:0] dir_req;
    logic       grow;
    logic [8:0] row;
    logic [9:0] col;
    logic       snake_r;
    logic       snake_head;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [4:0] length;
    logic       game_over;

    modport master (
        output move_tick, dir_req, grow, row, col,
        input  snake_r, snake_head, head_x, head_y, length, game_over
    );

    modport slave (
        input  move_tick, dir_req, grow, row, col,
        output snake_r, snake_head, head_x, head_y, length, game_over
    );
endinterface

// File: rtl/snake_body.sv
// Snake body: segment list on the cell grid, one-cell moves with steering,
// growth and wall/self collision, plus a registered per-pixel hit test that
// feeds the pixel-colour stage.
module snake_body #(
    parameter int MAX_LEN  = 16,
    parameter int CELL     = 20,
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 16,
    parameter int INIT_Y   = 12
) (
    input  logic     clk,
    input  logic     rst_n,
    snake_if.slave   bus
);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Segment 0 is the head; entries at index >= r_length are unused.
    logic [4:0] r_seg_x [MAX_LEN];
    logic [4:0] r_seg_y [MAX_LEN];
    logic [4:0] r_length;
    dir_e       r_cur_dir;
    logic       r_grow_pend;
    logic       r_game_over;
    logic       r_snake_r;
    logic       r_snake_head;

    dir_e               w_req_dir;
    dir_e               w_eff_dir;
    logic               w_reverse;
    logic [5:0]         w_nh_x;
    logic [5:0]         w_nh_y;
    logic               w_wall;
    logic               w_self;
    logic               w_move;
    logic               w_grow_eff;
    logic               w_can_grow;
    logic               w_on_screen;
    logic [MAX_LEN-1:0] w_seg_hit;

    // Up/down and left/right differ only in bit 0, so a reversal keeps bit 1.
    assign w_req_dir = dir_e'(bus.dir_req);
    assign w_reverse = (r_cur_dir[1] == bus.dir_req[1]) && (r_cur_dir[0] != bus.dir_req[0]);
    assign w_eff_dir = w_reverse ? r_cur_dir : w_req_dir;

    assign w_move     = bus.move_tick && !r_game_over;
    // A grow pulse arriving with the move tick still counts for that move.
    assign w_grow_eff = r_grow_pend || bus.grow;
    assign w_can_grow = w_grow_eff && (r_length < 5'(MAX_LEN));

    // Candidate head cell, widened to 6 bits so stepping below 0 wraps high
    // and is caught by the same upper-bound wall test.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_nh_x = {1'b0, r_seg_x[0]};
        w_nh_y = {1'b0, r_seg_y[0]};
        unique case (w_eff_dir)
            DIR_UP:    w_nh_y = {1'b0, r_seg_y[0]} - 6'd1;
            DIR_DOWN:  w_nh_y = {1'b0, r_seg_y[0]} + 6'd1;
            DIR_LEFT:  w_nh_x = {1'b0, r_seg_x[0]} - 6'd1;
            DIR_RIGHT: w_nh_x = {1'b0, r_seg_x[0]} + 6'd1;
        endcase
    end

    assign w_wall = (w_nh_x >= 6'(GRID_W)) || (w_nh_y >= 6'(GRID_H));

    // Self collision against every live segment except a tail that will vacate.
    always_comb begin
        w_self = 1'b0;
        for (int j = 0; j < MAX_LEN; j++) begin
            if ((j + 1 < int'(r_length)) || (w_can_grow && (j + 1 == int'(r_length)))) begin
                if ((w_nh_x == {1'b0, r_seg_x[j]}) && (w_nh_y == {1'b0, r_seg_y[j]}))
                    w_self = 1'b1;
            end
        end
    end

    // Per-segment pixel range compare; x span in 10 bits, y span in 9 bits.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
        logic [9:0] w_x_lo;
        logic [9:0] w_x_hi;
        logic [8:0] w_y_lo;
        logic [8:0] w_y_hi;
        assign w_x_lo = 10'(r_seg_x[g] * CELL);
        assign w_x_hi = w_x_lo + 10'(CELL);
        assign w_y_lo = 9'(r_seg_y[g] * CELL);
        assign w_y_hi = w_y_lo + 9'(CELL);
        assign w_seg_hit[g] = (5'(g) < r_length)
                            && (bus.col >= w_x_lo) && (bus.col < w_x_hi)
                            && (bus.row >= w_y_lo) && (bus.row < w_y_hi);
    end

    assign w_on_screen = (bus.row < 9'd480) && (bus.col < 10'd640);

    // Segment, length, direction and game-over state; frozen once game_over is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the segment array is reset because the starting body is a defined game state.
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? 5'(INIT_X - i) : 5'd0;
                r_seg_y[i] <= 5'(INIT_Y);
            end
            r_length    <= 5'(INIT_LEN);
            r_cur_dir   <= DIR_RIGHT;
            r_grow_pend <= 1'b0;
            r_game_over <= 1'b0;
        end else if (w_move) begin
            r_cur_dir <= w_eff_dir;
            if (w_wall || w_self) begin
                r_game_over <= 1'b1;
            end else begin
                // NOTE: non-blocking assignment makes every seg[i] take the pre-edge seg[i-1], giving a true shift.
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                r_seg_x[0]  <= w_nh_x[4:0];
                r_seg_y[0]  <= w_nh_y[4:0];
                r_length    <= r_length + (w_can_grow ? 5'd1 : 5'd0);
                r_grow_pend <= 1'b0;
            end
        end else if (bus.grow && !r_game_over) begin
            r_grow_pend <= 1'b1;
        end
    end

    // Registered pixel hit test against the pre-move segments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snake_r    <= 1'b0;
            r_snake_head <= 1'b0;
        end else begin
            r_snake_r    <= w_on_screen && (|w_seg_hit);
            r_snake_head <= w_on_screen && w_seg_hit[0];
        end
    end

    assign bus.snake_r    = r_snake_r;
    assign bus.snake_head = r_snake_head;
    assign bus.head_x     = r_seg_x[0];
    assign bus.head_y     = r_seg_y[0];
    assign bus.length     = r_length;
    assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: stimulus pushes expected responses for
// each probe cycle; a monitor pops and compares one clock later.
module tb_snake_body;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snake_if bus ();

    snake_body dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        bit         pix;
        logic       er;
        logic       eh;
        bit         stat;
        logic [4:0] hx;
        logic [4:0] hy;
        logic [4:0] len;
        logic       go;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic probe   = 1'b0;
    logic probe_d = 1'b0;

    always @(posedge clk) probe_d <= probe;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, one clock after the probe.
    always @(negedge clk) begin
        if (probe_d) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.pix) begin
                    check({mon_e.name, ".snake_r"},    16'(bus.snake_r),    16'(mon_e.er));
                    check({mon_e.name, ".snake_head"}, 16'(bus.snake_head), 16'(mon_e.eh));
                end
                if (mon_e.stat) begin
                    check({mon_e.name, ".head_x"},    16'(bus.head_x),    16'(mon_e.hx));
                    check({mon_e.name, ".head_y"},    16'(bus.head_y),    16'(mon_e.hy));
                    check({mon_e.name, ".length"},    16'(bus.length),    16'(mon_e.len));
                    check({mon_e.name, ".game_over"}, 16'(bus.game_over), 16'(mon_e.go));
                end
            end
        end
    end

    task automatic drive(input logic mt, input logic [1:0] dr, input logic gr,
                         input logic pr, input logic [8:0] r, input logic [9:0] c);
        @(posedge clk);
        #1;
        bus.move_tick = mt;
        bus.dir_req   = dr;
        bus.grow      = gr;
        bus.row       = r;
        bus.col       = c;
        probe         = pr;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 9'd0, 10'd0);
    endtask

    task automatic move(input logic [1:0] d, input logic g);
        drive(1'b1, d, g, 1'b0, 9'd0, 10'd0);
        idle();
    endtask

    task automatic pix(input string n, input logic [8:0] r, input logic [9:0] c,
                       input logic er, input logic eh);
        exp_t e;
        e.name = n; e.pix = 1'b1; e.er = er; e.eh = eh;
        e.stat = 1'b0; e.hx = '0; e.hy = '0; e.len = '0; e.go = 1'b0;
        sb.push_back(e);
        drive(1'b0, 2'd0, 1'b0, 1'b1, r, c);
    endtask

    task automatic stat(input string n, input logic [4:0] hx, input logic [4:0] hy,
                        input logic [4:0] len, input logic go);
        exp_t e;
        e.name = n; e.pix = 1'b0; e.er = 1'b0; e.eh = 1'b0;
        e.stat = 1'b1; e.hx = hx; e.hy = hy; e.len = len; e.go = go;
        sb.push_back(e);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 9'd0, 10'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        probe = 1'b0;
        bus.move_tick = 1'b0;
        bus.grow      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.move_tick = 1'b0;
        bus.dir_req   = 2'd0;
        bus.grow      = 1'b0;
        bus.row       = 9'd0;
        bus.col       = 10'd0;
        repeat (2) @(posedge clk);

        // Probes taken while reset is held: hit outputs forced low, state at init.
        pix("rst_pix", 9'd245, 10'd330, 1'b0, 1'b0);
        stat("rst_stat", 5'd16, 5'd12, 5'd3, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        probe = 1'b0;

        // Initial body occupies x=14..16 at y=12: cols 280..339, head 320..339, rows 240..259.
        for (int r = 239; r <= 260; r++) begin
            for (int c = 299; c <= 340; c++) begin
                pix("scan", 9'(r), 10'(c),
                    (r >= 240 && r <= 259 && c >= 280 && c <= 339),
                    (r >= 240 && r <= 259 && c >= 320 && c <= 339));
            end
        end

        // Four moves right.
        repeat (4) move(2'd3, 1'b0);
        stat("move4", 5'd20, 5'd12, 5'd3, 1'b0);
        pix("head400", 9'd240, 10'd400, 1'b1, 1'b1);
        pix("body380", 9'd240, 10'd380, 1'b1, 1'b0);
        pix("vacated340", 9'd240, 10'd340, 1'b0, 1'b0);

        // Reverse request (left while heading right) is ignored.
        move(2'd2, 1'b0);
        stat("reverse", 5'd21, 5'd12, 5'd3, 1'b0);

        // Two grow pulses before one move count once.
        drive(1'b0, 2'd0, 1'b1, 1'b0, 9'd0, 10'd0);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 9'd0, 10'd0);
        idle();
        move(2'd3, 1'b0);
        stat("grow1", 5'd22, 5'd12, 5'd4, 1'b0);
        pix("tail_kept", 9'd240, 10'd380, 1'b1, 1'b0);
        pix("past_tail", 9'd240, 10'd360, 1'b0, 1'b0);

        // Twelve grow+move pairs reach 16: 5 right, 7 up.
        repeat (5) move(2'd3, 1'b1);
        stat("grow_r5", 5'd27, 5'd12, 5'd9, 1'b0);
        repeat (7) move(2'd0, 1'b1);
        stat("sat16", 5'd27, 5'd5, 5'd16, 1'b0);
        move(2'd0, 1'b1);
        stat("sat16_13", 5'd27, 5'd4, 5'd16, 1'b0);
        move(2'd0, 1'b1);
        stat("sat16_more", 5'd27, 5'd3, 5'd16, 1'b0);

        // Right wall.
        repeat (4) move(2'd3, 1'b0);
        stat("at_edge", 5'd31, 5'd3, 5'd16, 1'b0);
        move(2'd3, 1'b0);
        stat("wall", 5'd31, 5'd3, 5'd16, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 9'd0, 10'd0);
        move(2'd0, 1'b1);
        stat("frozen", 5'd31, 5'd3, 5'd16, 1'b1);
        pix("go_head_pix", 9'd70, 10'd630, 1'b1, 1'b1);

        // One-clock reset restores the initial body.
        pulse_reset();
        stat("reset2", 5'd16, 5'd12, 5'd3, 1'b0);
        pix("reset2_head", 9'd245, 10'd330, 1'b1, 1'b1);

        // Length 5, then up, left, down runs the head into segment 3.
        repeat (2) move(2'd3, 1'b1);
        stat("len5", 5'd18, 5'd12, 5'd5, 1'b0);
        move(2'd0, 1'b0);
        move(2'd2, 1'b0);
        stat("pre_self", 5'd17, 5'd11, 5'd5, 1'b0);
        move(2'd1, 1'b0);
        stat("self", 5'd17, 5'd11, 5'd5, 1'b1);
        pix("self_head", 9'd220, 10'd340, 1'b1, 1'b1);
        pix("self_seg1", 9'd220, 10'd360, 1'b1, 1'b0);
        pix("self_seg3", 9'd240, 10'd340, 1'b1, 1'b0);
        pix("self_seg4", 9'd240, 10'd320, 1'b1, 1'b0);
        pix("self_gone", 9'd240, 10'd300, 1'b0, 1'b0);

        // Top wall: y=0 minus one must be caught.
        pulse_reset();
        repeat (12) move(2'd0, 1'b0);
        stat("top", 5'd16, 5'd0, 5'd3, 1'b0);
        move(2'd0, 1'b0);
        stat("top_wall", 5'd16, 5'd0, 5'd3, 1'b1);
        pix("offscreen", 9'd480, 10'd330, 1'b0, 1'b0);
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
